// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : global controller state encodings and shared constants
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam logic [2:0] STATE_IF  = 3'd0;
  localparam logic [2:0] STATE_ID  = 3'd1;
  localparam logic [2:0] STATE_EX  = 3'd2;
  localparam logic [2:0] STATE_MEM = 3'd3;
  localparam logic [2:0] STATE_WB  = 3'd4;

  // sll $0,$0,0
  localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : instruction-memory req/ready handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_watchdog.sv
// ============================================================================
// fetch_watchdog : counts cycles spent waiting in REQ, flags expiry
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic run_i,
  output logic      expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires during the TIMEOUT_CYCLES-th waiting cycle so the fetch gives up at its end.
  assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : IF stage - owns the PC, fetches one word per STATE_IF visit.
// Optional watchdog enabled by `define FETCH_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD       = FETCH_NOP_WORD,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [2:0]  state_i,
  input  wire logic        pc_load_i,
  input  wire logic [31:0] pc_next_i,
  fetch_unit_if.master     imem,
  output logic [31:0]      instruction_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             fetch_done_o,
  output logic             fetch_fault_o
);

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

  fetch_state_t fsm_q, fsm_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         done_q, done_d;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q, fault_d;
  logic w_expired;

  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (fsm_q == FS_REQ),
    .expired_o (w_expired)
  );
`endif

  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    done_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    fault_d = fault_q;
`endif
    case (fsm_q)
      FS_IDLE: begin
        if (state_i == STATE_IF) begin
          addr_d  = pc_q;
          req_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          fault_d = 1'b0;
`endif
          fsm_d   = FS_REQ;
        end
      end
      FS_REQ: begin
        // The handshake runs to completion even if the controller leaves STATE_IF.
        if (imem.ready) begin
          instr_d = imem.rdata;
          pc4_d   = addr_q + 32'd4;
          pc_d    = addr_q + 32'd4;
          req_d   = 1'b0;
          done_d  = 1'b1;
          fsm_d   = FS_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_expired) begin
          instr_d = NOP_WORD;
          req_d   = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
          fsm_d   = FS_DONE;
        end
`endif
      end
      FS_DONE: begin
        // Wait for the controller to leave STATE_IF so a lingering IF never refetches.
        if (state_i != STATE_IF) fsm_d = FS_IDLE;
      end
      default: fsm_d = FS_IDLE;
    endcase
    // A redirect overrides the post-capture increment.
    if (pc_load_i) pc_d = pc_next_i & ~32'h3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= FS_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
      instr_q <= NOP_WORD;
      pc4_q   <= RESET_PC;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      done_q  <= done_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fetch_fault_o = fault_q;
`else
  assign fetch_fault_o = 1'b0;
`endif

  assign imem.req      = req_q;
  assign imem.addr     = addr_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc4_q;
  assign fetch_done_o  = done_q;

endmodule

`default_nettype wire
